// File: rtl/karatsuba16_dot_acc.sv
// karatsuba16_dot_acc: streaming unsigned 16x16 dot-product accumulator built on a Karatsuba multiplier
//   clk, rst_n (async active-low), clear (sync abort/restart)
//   in_valid/in_ready/in_x/in_y    : operand pair stream
//   out_valid/out_ready/out_acc/out_ovf : finished dot product (sum mod 2^ACC_W, sticky carry)
module karatsuba16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);
  logic [15:0] z2, z0;
  logic [8:0]  as, bs;
  logic [17:0] z1;
  logic [16:0] mid;
  always_comb begin
    z2  = 16'(a[15:8]) * 16'(b[15:8]);
    z0  = 16'(a[7:0]) * 16'(b[7:0]);
    as  = {1'b0, a[15:8]} + {1'b0, a[7:0]};
    bs  = {1'b0, b[15:8]} + {1'b0, b[7:0]};
    z1  = 18'(as) * 18'(bs);
    // cross term a_hi*b_lo + a_lo*b_hi never exceeds 17 bits
    mid = 17'(z1 - {2'b0, z2} - {2'b0, z0});
    p   = {z2, z0} + {7'b0, mid, 8'b0};
  end
endmodule

module karatsuba16_dot_acc #(
  parameter int LEN   = 8,
  parameter int ACC_W = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_x,
  input  logic [15:0]      in_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf
);
  localparam int CNT_W = $clog2(LEN + 1);
  typedef enum logic [1:0] {S_ACC, S_FLUSH, S_OUT} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [15:0] x_q, x_d, y_q, y_d;
  logic [31:0] p_q, p_d, prod;
  logic v1_q, v1_d, v2_q, v2_d, ovf_q, ovf_d;
  logic accept, out_fire;
  logic [ACC_W:0] sum;
  karatsuba16 u_mul (.a(x_q), .b(y_q), .p(prod));
  assign in_ready  = state_q == S_ACC;
  assign out_valid = state_q == S_OUT;
  assign out_acc   = acc_q;
  assign out_ovf   = ovf_q;
  always_comb begin
    accept   = in_valid & in_ready & ~clear;
    out_fire = out_valid & out_ready;
    sum      = {1'b0, acc_q} + (ACC_W + 1)'(p_q);
    state_d  = state_q;
    cnt_d    = accept ? cnt_q + CNT_W'(1) : cnt_q;
    x_d      = accept ? in_x : x_q;
    y_d      = accept ? in_y : y_q;
    p_d      = prod;
    v1_d     = accept;
    v2_d     = v1_q;
    acc_d    = v2_q ? sum[ACC_W-1:0] : acc_q;
    ovf_d    = v2_q ? ovf_q | sum[ACC_W] : ovf_q;
    if (state_q == S_ACC && accept && cnt_q == CNT_W'(LEN - 1)) state_d = S_FLUSH;
    // the pair that entered S_FLUSH is the only one left in flight
    if (state_q == S_FLUSH && v2_q && !v1_q) state_d = S_OUT;
    if (out_fire) begin
      state_d = S_ACC;
      cnt_d   = '0;
      acc_d   = '0;
      ovf_d   = 1'b0;
    end
    if (clear) begin
      state_d = S_ACC;
      cnt_d   = '0;
      acc_d   = '0;
      ovf_d   = 1'b0;
      v1_d    = 1'b0;
      v2_d    = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_ACC;
      cnt_q   <= '0;
      acc_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      p_q     <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      y_q     <= y_d;
      p_q     <= p_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: tb/tb_karatsuba16_dot_acc.sv
// tb_karatsuba16_dot_acc: scoreboard bench for a LEN=4/ACC_W=40 and a LEN=2/ACC_W=32 engine
module tb_karatsuba16_dot_acc;
  logic clk = 0, rst_n = 0, clear = 0, out_ready = 1, a_iv = 0, b_iv = 0;
  logic [15:0] in_x = 0, in_y = 0;
  logic a_ir, a_ov, a_of, b_ir, b_ov, b_of;
  logic [39:0] a_acc;
  logic [31:0] b_acc;
  typedef struct packed {logic [39:0] acc; logic ovf;} exp_t;
  exp_t q[$];
  exp_t last_e;
  int total = 0, bad = 0;
  bit sel = 0;
  logic [63:0] msum = 0;
  logic o_valid, o_ready_in, o_ovf;
  logic [39:0] o_acc;
  always #5 clk = ~clk;
  karatsuba16_dot_acc #(.LEN(4), .ACC_W(40)) u_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(a_iv), .in_ready(a_ir),
    .in_x(in_x), .in_y(in_y), .out_valid(a_ov), .out_ready(out_ready),
    .out_acc(a_acc), .out_ovf(a_of));
  karatsuba16_dot_acc #(.LEN(2), .ACC_W(32)) u_b (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(b_iv), .in_ready(b_ir),
    .in_x(in_x), .in_y(in_y), .out_valid(b_ov), .out_ready(out_ready),
    .out_acc(b_acc), .out_ovf(b_of));
  assign o_valid    = sel ? b_ov : a_ov;
  assign o_ready_in = sel ? b_ir : a_ir;
  assign o_ovf      = sel ? b_of : a_of;
  assign o_acc      = sel ? {8'b0, b_acc} : a_acc;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [15:0] x, input logic [15:0] y, input int gap);
    int n = 0;
    repeat (gap) tick();
    in_x = x;
    in_y = y;
    if (sel) b_iv = 1; else a_iv = 1;
    while (!o_ready_in && n < 20) begin tick(); n++; end
    if (n == 20) chk("in_ready_timeout", o_ready_in, 1);
    tick();
    a_iv = 0;
    b_iv = 0;
    msum += 64'(x) * 64'(y);
  endtask
  task automatic finish_dot();
    int w = sel ? 32 : 40;
    exp_t e;
    e.acc = 40'(msum & ((64'd1 << w) - 1));
    e.ovf = (msum >> w) != 0;
    q.push_back(e);
    msum = 0;
  endtask
  task automatic get_result(input int exp_lat);
    int n = 0;
    while (!o_valid && n < 20) begin tick(); n++; end
    chk("out_valid_rise", o_valid, 1);
    if (exp_lat >= 0) chk("latency_edges", n, exp_lat);
    if (q.size() == 0) chk("scoreboard_empty", q.size(), 1);
    else begin
      last_e = q.pop_front();
      chk("out_acc", o_acc, last_e.acc);
      chk("out_ovf", o_ovf, last_e.ovf);
    end
    if (out_ready) begin
      tick();
      chk("post_hs_valid", o_valid, 0);
      chk("post_hs_ready", o_ready_in, 1);
      chk("post_hs_acc", o_acc, 0);
    end
  endtask
  initial begin
    #2;
    chk("rst_in_ready", a_ir, 1);
    chk("rst_out_valid", a_ov, 0);
    chk("rst_out_acc", a_acc, 0);
    chk("rst_out_ovf", a_of, 0);
    #10 rst_n = 1;
    tick();
    // T1 back-to-back, result rises after edge E+2 of the last accept
    for (int i = 1; i <= 4; i++) send(16'(i), 16'(i), 0);
    chk("t1_in_ready_drop", a_ir, 0);
    finish_dot();
    chk("t1_model", q[0].acc, 40'd30);
    get_result(2);
    // T2 max operands with random gaps
    for (int i = 0; i < 4; i++) send(16'hFFFF, 16'hFFFF, $urandom_range(0, 3));
    finish_dot();
    chk("t2_model", q[0].acc, 40'h3_FFF8_0004);
    get_result(2);
    // T3 narrow accumulator wraps and flags, then restarts clean
    sel = 1;
    send(16'hFFFF, 16'hFFFF, 0);
    send(16'hFFFF, 16'hFFFF, 0);
    finish_dot();
    chk("t3_model", {q[0].acc, q[0].ovf}, {40'hFFFC_0002, 1'b1});
    get_result(2);
    send(1, 1, 0);
    send(1, 1, 1);
    finish_dot();
    get_result(2);
    sel = 0;
    // T4 backpressure holds the result and blocks input
    out_ready = 0;
    for (int i = 0; i < 4; i++) send(2, 3, 0);
    finish_dot();
    get_result(2);
    in_x = 16'h1234;
    in_y = 16'h4321;
    a_iv = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_hold_valid", a_ov, 1);
      chk("t4_hold_acc", a_acc, last_e.acc);
      chk("t4_in_ready", a_ir, 0);
    end
    a_iv = 0;
    out_ready = 1;
    tick();
    chk("t4_release_valid", a_ov, 0);
    chk("t4_release_ready", a_ir, 1);
    // T5 clear beats a concurrent accept and drops partial sums
    send(3, 3, 0);
    send(3, 3, 0);
    in_x = 9;
    in_y = 9;
    a_iv = 1;
    clear = 1;
    tick();
    clear = 0;
    a_iv = 0;
    msum = 0;
    chk("t5_clear_acc", a_acc, 0);
    chk("t5_clear_ready", a_ir, 1);
    repeat (3) tick();
    chk("t5_no_late_add", a_acc, 0);
    for (int i = 0; i < 4; i++) send(5, 6, 0);
    finish_dot();
    chk("t5_model", q[0].acc, 40'd120);
    get_result(2);
    // T6 async reset during flush
    for (int i = 0; i < 4; i++) send(16'h0100, 16'h0100, 0);
    msum = 0;
    tick();
    rst_n = 0;
    #1;
    chk("t6_rst_valid", a_ov, 0);
    chk("t6_rst_ready", a_ir, 1);
    chk("t6_rst_acc", a_acc, 0);
    #2 rst_n = 1;
    tick();
    for (int i = 0; i < 4; i++) send(7, 8, 0);
    finish_dot();
    chk("t6_model", q[0].acc, 40'd224);
    get_result(2);
    chk("scoreboard_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
